// File: rtl/wb_ram_arbiter_if.sv
// Bus bundle between the three Wishbone masters, the arbiter and the shared RAM.
// Valid/ready: a master holds cyc and its request fields stable until it sees its ack (or aborts by dropping cyc).
interface wb_ram_arbiter_if;
    logic [31:0] i_wb_ibus_adr;
    logic        i_wb_ibus_cyc;
    logic [31:0] o_wb_ibus_rdt;
    logic        o_wb_ibus_ack;

    logic [31:0] i_wb_dbus_adr;
    logic [31:0] i_wb_dbus_dat;
    logic [3:0]  i_wb_dbus_sel;
    logic        i_wb_dbus_we;
    logic        i_wb_dbus_cyc;
    logic [31:0] o_wb_dbus_rdt;
    logic        o_wb_dbus_ack;

    logic [31:0] i_wb_dm_adr;
    logic [31:0] i_wb_dm_dat;
    logic [3:0]  i_wb_dm_sel;
    logic        i_wb_dm_we;
    logic        i_wb_dm_cyc;
    logic [31:0] o_wb_dm_rdt;
    logic        o_wb_dm_ack;

    logic [31:0] o_wb_mem_adr;
    logic [31:0] o_wb_mem_dat;
    logic [3:0]  o_wb_mem_sel;
    logic        o_wb_mem_we;
    logic        o_wb_mem_cyc;
    logic [31:0] i_wb_mem_rdt;
    logic        i_wb_mem_ack;

    // Arbiter view: slave to the CPU/debug masters, master towards the RAM.
    modport slave (
        input  i_wb_ibus_adr, i_wb_ibus_cyc,
        output o_wb_ibus_rdt, o_wb_ibus_ack,
        input  i_wb_dbus_adr, i_wb_dbus_dat, i_wb_dbus_sel, i_wb_dbus_we, i_wb_dbus_cyc,
        output o_wb_dbus_rdt, o_wb_dbus_ack,
        input  i_wb_dm_adr, i_wb_dm_dat, i_wb_dm_sel, i_wb_dm_we, i_wb_dm_cyc,
        output o_wb_dm_rdt, o_wb_dm_ack,
        output o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
        input  i_wb_mem_rdt, i_wb_mem_ack
    );

    // Environment view: drives master requests and the RAM response.
    modport master (
        output i_wb_ibus_adr, i_wb_ibus_cyc,
        input  o_wb_ibus_rdt, o_wb_ibus_ack,
        output i_wb_dbus_adr, i_wb_dbus_dat, i_wb_dbus_sel, i_wb_dbus_we, i_wb_dbus_cyc,
        input  o_wb_dbus_rdt, o_wb_dbus_ack,
        output i_wb_dm_adr, i_wb_dm_dat, i_wb_dm_sel, i_wb_dm_we, i_wb_dm_cyc,
        input  o_wb_dm_rdt, o_wb_dm_ack,
        input  o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
        output i_wb_mem_rdt, i_wb_mem_ack
    );
endinterface

// File: rtl/wb_ram_arbiter.sv
// Three-master (ibus, dbus, debug module) arbiter onto one Wishbone RAM port, IDLE/BUSY FSM.
// Optional access timeout with forced error acknowledge is enabled by defining WB_ARB_TIMEOUT_EN.
module wb_ram_arbiter #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic            i_clk,
    input  logic            i_rst,
    wb_ram_arbiter_if.slave bus,
    input  logic            i_err_clr,
    output logic [1:0]      o_grant,
    output logic            o_timeout_err,
    output logic            o_state_dbg
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_IBUS = 2'd1;
    localparam logic [1:0] G_DBUS = 2'd2;
    localparam logic [1:0] G_DM   = 2'd3;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    logic [0:0]  r_state;
    logic [1:0]  r_grant;
    logic        r_last_dbus;

    logic        w_busy;
    logic [1:0]  w_winner;
    logic        w_gnt_cyc;
    logic [31:0] w_adr;
    logic [31:0] w_dat;
    logic [3:0]  w_sel;
    logic        w_we;
    logic        w_slv_ack;
    logic        w_timeout;
    logic        w_mst_ack;
    logic [31:0] w_mst_rdt;
    logic        w_done;

    // Reset gates every combinational output so nothing leaks in the reset cycle.
    assign w_busy = (r_state == BUSY) && !i_rst;

    always_comb begin
        w_winner = G_NONE;
        if (bus.i_wb_dm_cyc)
            w_winner = G_DM;
        else if (bus.i_wb_ibus_cyc && bus.i_wb_dbus_cyc)
            w_winner = r_last_dbus ? G_IBUS : G_DBUS;
        else if (bus.i_wb_ibus_cyc)
            w_winner = G_IBUS;
        else if (bus.i_wb_dbus_cyc)
            w_winner = G_DBUS;
    end

    always_comb begin
        w_gnt_cyc = 1'b0;
        w_adr     = 32'd0;
        w_dat     = 32'd0;
        w_sel     = 4'd0;
        w_we      = 1'b0;
        if (w_busy) begin
            case (r_grant)
                G_IBUS: begin
                    w_gnt_cyc = bus.i_wb_ibus_cyc;
                    w_adr     = bus.i_wb_ibus_adr;
                    w_sel     = 4'hF;
                end
                G_DBUS: begin
                    w_gnt_cyc = bus.i_wb_dbus_cyc;
                    w_adr     = bus.i_wb_dbus_adr;
                    w_dat     = bus.i_wb_dbus_dat;
                    w_sel     = bus.i_wb_dbus_sel;
                    w_we      = bus.i_wb_dbus_we;
                end
                G_DM: begin
                    w_gnt_cyc = bus.i_wb_dm_cyc;
                    w_adr     = bus.i_wb_dm_adr;
                    w_dat     = bus.i_wb_dm_dat;
                    w_sel     = bus.i_wb_dm_sel;
                    w_we      = bus.i_wb_dm_we;
                end
                default: ;
            endcase
        end
    end

    assign w_slv_ack = w_gnt_cyc && bus.i_wb_mem_ack;

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] r_wait_cnt;
    logic        r_timeout_err;

    // A slave ack in the same cycle as the limit wins over the timeout.
    assign w_timeout = w_gnt_cyc && !bus.i_wb_mem_ack && (r_wait_cnt == TIMEOUT_W);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait_cnt    <= 16'd0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_wait_cnt <= 16'd0;
            else if (!bus.i_wb_mem_ack && (r_wait_cnt != 16'hFFFF))
                r_wait_cnt <= r_wait_cnt + 16'd1;
            if (w_timeout)
                r_timeout_err <= 1'b1;
            else if (i_err_clr)
                r_timeout_err <= 1'b0;
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    logic w_unused;
    assign w_unused      = ^{i_err_clr, TIMEOUT_W};
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign w_mst_ack = w_slv_ack || w_timeout;
    assign w_mst_rdt = w_timeout ? ERR_DATA : bus.i_wb_mem_rdt;
    assign w_done    = w_mst_ack || !w_gnt_cyc;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_grant     <= G_NONE;
            r_last_dbus <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_grant <= w_winner;
                    if (w_winner != G_NONE)
                        r_state <= BUSY;
                end
                BUSY: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_grant <= G_NONE;
                        // Aborts leave the fairness bit alone; only acked ibus/dbus cycles count.
                        if (w_mst_ack && (r_grant == G_IBUS))
                            r_last_dbus <= 1'b0;
                        else if (w_mst_ack && (r_grant == G_DBUS))
                            r_last_dbus <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= G_NONE;
                end
            endcase
        end
    end

    assign bus.o_wb_mem_adr = w_adr;
    assign bus.o_wb_mem_dat = w_dat;
    assign bus.o_wb_mem_sel = w_sel;
    assign bus.o_wb_mem_we  = w_we;
    assign bus.o_wb_mem_cyc = w_gnt_cyc && !w_timeout;

    assign bus.o_wb_ibus_ack = w_mst_ack && (r_grant == G_IBUS);
    assign bus.o_wb_dbus_ack = w_mst_ack && (r_grant == G_DBUS);
    assign bus.o_wb_dm_ack   = w_mst_ack && (r_grant == G_DM);

    assign bus.o_wb_ibus_rdt = (w_busy && (r_grant == G_IBUS)) ? w_mst_rdt : 32'd0;
    assign bus.o_wb_dbus_rdt = (w_busy && (r_grant == G_DBUS)) ? w_mst_rdt : 32'd0;
    assign bus.o_wb_dm_rdt   = (w_busy && (r_grant == G_DM))   ? w_mst_rdt : 32'd0;

    assign o_grant     = r_grant;
    assign o_state_dbg = r_state;
endmodule

// File: doc/wb_ram_arbiter.md
WB_RAM_ARBITER -- requirements
Module: wb_ram_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning the maximum number of wait cycles before a forced error acknowledge (legal range 2..65535).
REQ-002 The block SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, meaning the read data returned on a timed-out access.
REQ-003 i_clk  in  1  system clock; all logic is on the rising edge.
REQ-004 i_rst  in  1  synchronous reset, active high.
REQ-005 i_wb_ibus_adr in 32, i_wb_ibus_cyc in 1, o_wb_ibus_rdt out 32, o_wb_ibus_ack out 1: CPU instruction master (read only).
REQ-006 i_wb_dbus_adr in 32, i_wb_dbus_dat in 32, i_wb_dbus_sel in 4, i_wb_dbus_we in 1, i_wb_dbus_cyc in 1, o_wb_dbus_rdt out 32, o_wb_dbus_ack out 1: CPU data master.
REQ-007 i_wb_dm_adr in 32, i_wb_dm_dat in 32, i_wb_dm_sel in 4, i_wb_dm_we in 1, i_wb_dm_cyc in 1, o_wb_dm_rdt out 32, o_wb_dm_ack out 1: debug-module system-bus master.
REQ-008 o_wb_mem_adr out 32, o_wb_mem_dat out 32, o_wb_mem_sel out 4, o_wb_mem_we out 1, o_wb_mem_cyc out 1, i_wb_mem_rdt in 32, i_wb_mem_ack in 1: shared RAM slave port.
REQ-009 o_grant out 2: current owner (0 none, 1 ibus, 2 dbus, 3 dm).
REQ-010 o_timeout_err out 1: sticky timeout flag; i_err_clr in 1 clears it.

Function
REQ-011 FSM states SHALL be IDLE and BUSY only.
REQ-012 IDLE: if any master cyc is high, register the winner into grant, clear the wait counter, go to BUSY next cycle; slave cyc stays low in IDLE (one cycle arbitration latency).
REQ-013 Priority: dm beats ibus/dbus; between ibus and dbus, a last-served bit selects the one not served last when both request; a lone requester always wins.
REQ-014 Last-served bit SHALL update only when an ibus or dbus transaction completes by ack (slave or timeout).
REQ-015 BUSY: slave adr/dat/sel/we SHALL mux from the granted master; o_wb_mem_cyc = granted master's cyc; ibus grant drives we=0, sel=4'hF, dat=0.
REQ-016 Outside BUSY, slave adr/dat/sel/we SHALL be zero.
REQ-017 i_wb_mem_ack in BUSY SHALL combinationally assert only the granted master's ack and pass i_wb_mem_rdt; FSM returns to IDLE next cycle; non-granted acks stay 0.
REQ-018 o_*_rdt of non-granted masters SHALL be zero.
REQ-019 i_wb_mem_ack in IDLE SHALL be ignored.
REQ-020 Granted master dropping cyc in BUSY without ack (abort): return to IDLE next cycle, no ack issued, last-served unchanged.
REQ-021 A master re-asserting cyc right after its ack is re-arbitrated in IDLE; no back-to-back BUSY without passing IDLE.
REQ-022 A request arriving during BUSY is never pre-empting; it waits until IDLE.
REQ-023 Wait counter (16 bit, saturating) SHALL increment each BUSY cycle without slave ack.

Reset
REQ-024 On i_rst: state IDLE, grant 0, counter 0, last-served = dbus (so ibus wins first tie), o_timeout_err 0; all acks, slave cyc, slave data outputs 0 during and after the reset cycle.
REQ-025 Reset mid-transaction SHALL abandon it silently; a later slave ack is ignored.

Configuration
REQ-026 Macro WB_ARB_TIMEOUT_EN: when defined, if the counter reaches TIMEOUT in BUSY with no slave ack, the block SHALL drop o_wb_mem_cyc, ack the granted master with rdt=ERR_DATA for exactly one cycle, set o_timeout_err, and return to IDLE.
REQ-027 Slave ack in the same cycle as counter==TIMEOUT SHALL win (normal completion, no error).
REQ-028 i_err_clr clears o_timeout_err next cycle; a simultaneous new timeout SHALL keep it set.
REQ-029 Without WB_ARB_TIMEOUT_EN: no counter logic, BUSY waits indefinitely, o_timeout_err tied 0, i_err_clr ignored.

Verification
REQ-030 ibus read adr 0x100 alone, RAM acks 1 cycle after cyc -> o_grant=1, ibus_ack 1 cycle with RAM data, grant 0 next cycle.
REQ-031 ibus and dbus cyc same cycle twice in a row after reset -> first grant ibus, second grant dbus.
REQ-032 dm and dbus request during an ibus transaction -> after ibus ack, dm granted first, then dbus.
REQ-033 dbus write adr 0x2000 dat 0x12345678 sel 4'b0011 -> identical values on mem port; dbus_ack only; ibus_ack and dm_ack stay 0.
REQ-034 (WB_ARB_TIMEOUT_EN, TIMEOUT=4) dm read, RAM never acks -> dm_ack after 4 wait cycles, rdt 0xDEADBEEF, o_timeout_err=1 until i_err_clr.
REQ-035 Reset asserted in BUSY with RAM ack next cycle -> no master ack, o_grant=0, state IDLE.
